// File: rtl/int_ctrl_s.sv
// Interrupt controller: masked fixed-priority arbitration, vectored CPU request, ack/clear pulses.
// Optional INTC_SPURIOUS_CNT_EN adds a saturating withdrawn-request counter at offset 6.
module int_ctrl_s #(
    parameter int unsigned ADDRESS           = 0,
    parameter int unsigned BUS_ADDR_DATA_LEN = 16,
    parameter int unsigned NR_INT            = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    output logic                         req_bus,
    input  logic [NR_INT-1:0]            int_in,
    output logic [NR_INT-1:0]            int_rst,
    output logic                         int_req,
    output logic [4:0]                   int_vect,
    input  logic                         int_ack,
    input  logic                         reti
);

    localparam int unsigned AW1 = BUS_ADDR_DATA_LEN + 1;
    localparam logic [AW1-1:0] WIN_LO = AW1'(ADDRESS);
    localparam logic [AW1-1:0] WIN_HI = AW1'(ADDRESS + 8);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

    state_t            state;
    logic              gie;
    logic              busy;
    logic [4:0]        cur_idx;
    logic [NR_INT-1:0] mask_r;

    logic [2:0]        off;
    logic              we;
    logic [15:0]       mask16;
    logic [15:0]       mask_wr16;
    logic [15:0]       pend16;
    logic [NR_INT-1:0] eligible;
    logic [15:0]       elig16;
    logic [4:0]        win_idx;
    logic [15:0]       ack_oh;
    logic              withdraw;
    logic [7:0]        spur_rd;

    assign off      = addr[2:0];
    assign req_bus  = (AW1'(addr) >= WIN_LO) && (AW1'(addr) < WIN_HI);
    assign we       = wr && req_bus;
    assign mask16   = 16'(mask_r);
    assign pend16   = 16'(int_in);
    assign eligible = int_in & mask_r & {NR_INT{gie}};
    assign elig16   = 16'(eligible);
    assign ack_oh   = 16'(1) << cur_idx[3:0];
    assign withdraw = (state == S_REQ) && !int_ack && !elig16[cur_idx[3:0]];

    // Lowest set index wins; scan downward so the last hit is the winner.
    always_comb begin
        win_idx = '0;
        for (int i = int'(NR_INT) - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = 5'(i);
        end
    end

    always_comb begin
        mask_wr16 = mask16;
        if (we && off == 3'd2) mask_wr16[7:0]  = bus_in;
        if (we && off == 3'd3) mask_wr16[15:8] = bus_in;
    end

    always_comb begin
        bus_out = 8'h00;
        if (req_bus && rd) begin
            case (off)
                3'd0:    bus_out = {7'b0, gie};
                3'd1:    bus_out = {busy, 2'b00, cur_idx};
                3'd2:    bus_out = mask16[7:0];
                3'd3:    bus_out = mask16[15:8];
                3'd4:    bus_out = pend16[7:0];
                3'd5:    bus_out = pend16[15:8];
                3'd6:    bus_out = spur_rd;
                default: bus_out = 8'h00;
            endcase
        end
    end

    // Registers and the request/service state machine; arbitration sees pre-write register values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            gie      <= 1'b0;
            mask_r   <= '0;
            busy     <= 1'b0;
            cur_idx  <= '0;
            int_req  <= 1'b0;
            int_vect <= '0;
            int_rst  <= '0;
        end else begin
            int_rst <= '0;
            mask_r  <= mask_wr16[NR_INT-1:0];
            if (we && off == 3'd0) gie <= bus_in[0];
            case (state)
                S_IDLE: begin
                    if (|eligible) begin
                        cur_idx  <= win_idx;
                        int_vect <= win_idx + 5'd1;
                        int_req  <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (int_ack) begin
                        int_rst  <= ack_oh[NR_INT-1:0];
                        int_req  <= 1'b0;
                        int_vect <= '0;
                        busy     <= 1'b1;
                        state    <= S_SVC;
                    end else if (withdraw) begin
                        int_req  <= 1'b0;
                        int_vect <= '0;
                        cur_idx  <= '0;
                        state    <= S_IDLE;
                    end
                end
                S_SVC: begin
                    if (reti) begin
                        busy    <= 1'b0;
                        cur_idx <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef INTC_SPURIOUS_CNT_EN
    logic [7:0] spur_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spur_cnt <= '0;
        end else if (we && off == 3'd6) begin
            spur_cnt <= '0;
        end else if (withdraw && spur_cnt != 8'hFF) begin
            spur_cnt <= spur_cnt + 8'd1;
        end
    end

    assign spur_rd = spur_cnt;
`else
    assign spur_rd = 8'h00;
`endif

endmodule

// File: tb/tb_int_ctrl_s.sv
// Directed bench for int_ctrl_s: arbitration, ack/reti flow, withdrawal, masking, reset.
module tb_int_ctrl_s;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        wr, rd;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        req_bus;
    logic [15:0] int_in;
    logic [15:0] int_rst;
    logic        int_req;
    logic [4:0]  int_vect;
    logic        int_ack, reti;

    int total = 0;
    int bad   = 0;

    int_ctrl_s #(.ADDRESS(0), .BUS_ADDR_DATA_LEN(16), .NR_INT(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd),
        .bus_in(bus_in), .bus_out(bus_out), .req_bus(req_bus),
        .int_in(int_in), .int_rst(int_rst), .int_req(int_req),
        .int_vect(int_vect), .int_ack(int_ack), .reti(reti)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [7:0] d);
        addr   = 16'(off);
        bus_in = d;
        wr     = 1'b1;
        tick();
        wr     = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] off, input logic [7:0] exp);
        logic [7:0] d;
        addr = 16'(off);
        rd   = 1'b1;
        #1;
        d    = bus_out;
        rd   = 1'b0;
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [4:0] vect,
                           input logic [15:0] rstv);
        chk({tag, "_req"},  32'(int_req),  32'(req));
        chk({tag, "_vect"}, 32'(int_vect), 32'(vect));
        chk({tag, "_rst"},  32'(int_rst),  32'(rstv));
    endtask

    initial begin
        rst = 1'b0; addr = '0; wr = 1'b0; rd = 1'b0; bus_in = '0;
        int_in = '0; int_ack = 1'b0; reti = 1'b0;
        tick();
        chk_out("reset", 1'b0, 5'd0, 16'h0000);
        chk_reg("reset_ctrl", 3'd0, 8'h00);
        rst = 1'b1;
        tick();

        // Basic request, ack, reti flow
        wr_reg(3'd0, 8'h01);
        wr_reg(3'd2, 8'h0C);
        int_in = 16'h000C;
        chk("pre_latency_req", 32'(int_req), 32'd0);
        tick();
        chk_out("req_src2", 1'b1, 5'd3, 16'h0000);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_out("ack_src2", 1'b0, 5'd0, 16'h0004);
        chk_reg("status_svc", 3'd1, 8'h82);
        int_in = 16'h0008;
        tick();
        chk_out("svc_hold", 1'b0, 5'd0, 16'h0000);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk_reg("status_reti", 3'd1, 8'h00);
        chk("reti_no_req_yet", 32'(int_req), 32'd0);
        tick();
        chk_out("req_src3", 1'b1, 5'd4, 16'h0000);

        // No re-arbitration while a request is pending
        int_in = 16'h0009;
        wr_reg(3'd2, 8'h09);
        tick();
        chk_out("no_rearb", 1'b1, 5'd4, 16'h0000);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_out("ack_src3", 1'b0, 5'd0, 16'h0008);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();
        chk_out("req_src0", 1'b1, 5'd1, 16'h0000);

        // Withdrawn request
        int_in = 16'h0000;
        tick();
        chk_out("withdraw", 1'b0, 5'd0, 16'h0000);
        tick();
        chk_out("withdraw_idle", 1'b0, 5'd0, 16'h0000);
`ifdef INTC_SPURIOUS_CNT_EN
        chk_reg("spur_one", 3'd6, 8'h01);
        for (int i = 0; i < 300; i++) begin
            int_in = 16'h0001;
            tick();
            int_in = 16'h0000;
            tick();
        end
        chk_reg("spur_sat", 3'd6, 8'hFF);
        wr_reg(3'd6, 8'h5A);
        chk_reg("spur_clr", 3'd6, 8'h00);
`else
        chk_reg("spur_absent", 3'd6, 8'h00);
        wr_reg(3'd6, 8'h5A);
        chk_reg("spur_absent_wr", 3'd6, 8'h00);
`endif

        // Mask write coinciding with arbitration uses the old mask
        int_in = 16'h0001;
        wr_reg(3'd2, 8'h00);
        chk_out("prewrite_mask", 1'b1, 5'd1, 16'h0000);
        tick();
        chk_out("mask_withdraw", 1'b0, 5'd0, 16'h0000);
        int_in = 16'h0000;
        wr_reg(3'd2, 8'h09);

        // Ack and withdrawal in the same cycle: ack wins
        int_in = 16'h0008;
        tick();
        chk_out("req_src3_b", 1'b1, 5'd4, 16'h0000);
        int_ack = 1'b1;
        int_in  = 16'h0000;
        tick();
        int_ack = 1'b0;
        chk_out("ack_vs_drop", 1'b0, 5'd0, 16'h0008);
        chk_reg("status_ack_drop", 3'd1, 8'h83);
        reti = 1'b1;
        tick();
        reti = 1'b0;

        // Global enable gating
        wr_reg(3'd0, 8'h00);
        wr_reg(3'd2, 8'hFF);
        wr_reg(3'd3, 8'hFF);
        int_in = 16'hFFFF;
        tick();
        tick();
        chk("gie_off_req", 32'(int_req), 32'd0);
        chk_reg("pend0", 3'd4, 8'hFF);
        chk_reg("pend1", 3'd5, 8'hFF);
        chk_reg("mask1", 3'd3, 8'hFF);
        wr_reg(3'd0, 8'h01);
        chk("gie_write_edge", 32'(int_req), 32'd0);
        tick();
        chk_out("gie_on", 1'b1, 5'd1, 16'h0000);

        // Asynchronous reset during service
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_out("ack_src0", 1'b0, 5'd0, 16'h0001);
        chk_reg("status_svc0", 3'd1, 8'h80);
        #1;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 5'd0, 16'h0000);
        chk_reg("async_ctrl", 3'd0, 8'h00);
        chk_reg("async_mask0", 3'd2, 8'h00);
        chk_reg("async_status", 3'd1, 8'h00);
        tick();
        rst = 1'b1;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_out("ack_ignored", 1'b0, 5'd0, 16'h0000);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk_reg("reti_ignored", 3'd1, 8'h00);

        // Out-of-window address
        addr = 16'h0008;
        rd   = 1'b1;
        #1;
        chk("req_bus_out", 32'(req_bus), 32'd0);
        chk("bus_out_unsel", 32'(bus_out), 32'd0);
        rd   = 1'b0;
        addr = 16'h0007;
        #1;
        chk("req_bus_in", 32'(req_bus), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_ctrl_s.md
Name: int_ctrl_s

Overview:
- Interrupt controller directly downstream of the parallel-IO and other bus peripherals.
- Collects up to 16 synchronous, level-type `int` lines and applies mask and fixed priority.
- Presents one vectored request to the CPU core and returns a one-cycle `int_rst` clear pulse to the winning peripheral when the CPU accepts.
- Register access uses the same byte bus as the peripherals: addr/wr/rd/bus_in/bus_out/req_bus.

Parameters:
- ADDRESS, 0, base byte address of the 8-byte register window.
- BUS_ADDR_DATA_LEN, 16, width of addr.
- NR_INT, 16, number of interrupt sources, 1..16; unused mask/pending bits read 0 and ignore writes.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  BUS_ADDR_DATA_LEN  bus address.
- wr  in  1  write strobe.
- rd  in  1  read strobe.
- bus_in  in  8  write data.
- bus_out  out  8  read data; 0 when not selected.
- req_bus  out  1  high when ADDRESS <= addr < ADDRESS+8.
- int_in  in  NR_INT  peripheral interrupt levels; synchronous to clk.
- int_rst  out  NR_INT  one-cycle acknowledge/clear pulse per source.
- int_req  out  1  request to CPU.
- int_vect  out  5  source index+1 of the current request; 0 = none.
- int_ack  in  1  CPU accepts the current vector (single-cycle pulse).
- reti  in  1  CPU finished the handler (single-cycle pulse).

Behaviour:
- Register map (offset = addr[2:0]), reads combinational:
  - 0 CTRL: bit0 GIE, R/W.
  - 1 STATUS: RO, {busy, 2'b0, cur_idx[4:0]}.
  - 2 MASK0: sources 7:0. 3 MASK1: sources 15:8. Both R/W.
  - 4 PEND0 / 5 PEND1: RO, raw int_in.
  - 6 SPUR: see Optional Feature.
  - 7: reads 0.
- Reset: GIE=0, MASK=0, FSM=IDLE, int_req=0, int_vect=0, int_rst=0, cur_idx=0, busy=0. Reset mid-operation drops any request or service immediately.
- eligible = int_in & MASK & {NR_INT{GIE}}. Winner = lowest set index (index 0 highest priority).
- IDLE:
  - if eligible != 0: latch cur_idx=winner, int_vect=winner+1, int_req=1 registered.
  - Latency: int_in rising at edge n gives int_req high after edge n+1.
- REQ:
  - int_req held; int_vect stable, with no re-arbitration even if a higher-priority source appears.
  - On int_ack: int_rst[cur_idx]=1 for exactly one cycle; int_req=0; int_vect=0; busy=1; go SVC.
  - Else if eligible[cur_idx]=0 (source withdrew, masked, or GIE cleared): int_req=0, int_vect=0, go IDLE (withdrawn request).
  - int_ack and withdrawal in the same cycle: ack wins.
- SVC:
  - No new request is raised.
  - On reti: busy=0, go IDLE. Earliest next int_req is 2 cycles after reti.
- Edge cases:
  - int_ack in IDLE or SVC is ignored.
  - reti in IDLE or REQ is ignored.
  - A bus write to MASK/CTRL in the same cycle as arbitration: arbitration uses pre-write values.
- int_rst bits other than cur_idx stay 0. int_rst is never asserted outside the REQ→SVC transition.

Optional Feature:
- Macro: INTC_SPURIOUS_CNT_EN.
- Defined:
  - 8-bit counter SPUR at offset 6 increments on every REQ→IDLE withdrawal, saturating at 255.
  - Any write to offset 6 clears it.
  - Reset value 0.
- Undefined: no counter logic; offset 6 reads 0 and writes are ignored.

Test Plan:
- GIE=1, MASK0=0x0C, int_in=0x000C → int_req high one cycle later, int_vect=3. int_ack → int_rst=0x0004 for one cycle; STATUS=0x82. reti → STATUS=0x00; with int_in=0x0008, int_req=1 and int_vect=4 within 2 cycles.
- In REQ with int_vect=4, raise int_in[0] with MASK0=0x09 → int_vect stays 4 until ack; after reti, next vector is 1.
- In REQ, clear int_in[3] before ack → int_req=0 next cycle, no int_rst pulse. With INTC_SPURIOUS_CNT_EN, SPUR reads 1; after 300 withdrawals it reads 255; write offset 6 → 0.
- Same cycle: int_ack=1 and int_in source drops → int_rst pulse issued, FSM enters SVC.
- GIE=0, int_in=0xFFFF, MASK=0xFFFF → int_req stays 0; PEND0/PEND1 read 0xFF/0xFF. Set GIE=1 → int_vect=1.
- Assert rst low while in SVC → all outputs 0 and CTRL/MASK read 0 asynchronously. After release, int_ack/reti pulses are ignored until a new request.
